poly_mul_csr_param: RTL and testbench



---
 rtl/poly_mul_pkg.sv | 21 ++
 rtl/csr_rotate.sv | 41 ++++
 rtl/poly_mul_csr_param.sv | 139 +++++++++++++
 tb/tb_poly_mul_csr_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/poly_mul_pkg.sv
// Shared types and helpers for the CSR-based polynomial multiplier.
package poly_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Two's-complement negation of x reduced mod 2^q (q up to 64 bits).
  function automatic logic [63:0] neg_mod(input logic [63:0] x, input int unsigned q);
    logic [63:0] mask;
    mask = (q >= 64) ? '1 : ((64'd1 << q) - 64'd1);
    return (~x + 64'd1) & mask;
  endfunction

  // Bit offset of coefficient idx in a packed vector of width-bit coefficients.
  function automatic int unsigned coef_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/csr_rotate.sv
// N x W circular shift register: parallel load, rotate-up by one coefficient,
// optionally negating the coefficient that wraps from the top back to slot 0.
module csr_rotate
  import poly_mul_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = 2,
  parameter int NEGATE_WRAP = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [N*W-1:0] load_data,
  input  logic           rot,
  output logic [N*W-1:0] q
);

  logic [W-1:0] top;
  logic [W-1:0] wrap;

  // The wrapped coefficient is negated for negacyclic reduction (x^N = -1).
  always_comb begin
    top  = q[(N-1)*W +: W];
    wrap = top;
    if (NEGATE_WRAP != 0) begin
      wrap = W'(neg_mod(64'(top), W));
    end
  end

  // Load has priority over rotation; slot i takes slot i-1, slot 0 takes the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (rot) begin
      q <= {q[(N-1)*W-1:0], wrap};
    end
  end

endmodule

// File: rtl/poly_mul_csr_param.sv
// Schoolbook polynomial multiplier c = a*b mod (x^N -/+ 1), coefficients mod 2^Q.
// CSR-A feeds one coefficient of a per cycle; CSR-B rotates b so that every
// accumulator sees the correctly aligned (and sign-adjusted) b term each cycle.
module poly_mul_csr_param
  import poly_mul_pkg::*;
#(
  parameter int N          = 4,
  parameter int CW         = 1,
  parameter int Q          = 2,
  parameter int NEGACYCLIC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N*CW-1:0] a_in,
  input  logic [N*CW-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic [N*Q-1:0]  c_out
);

  localparam int CNTW = $clog2(N);

  state_t          state_q;
  state_t          state_d;
  logic            load;
  logic            step;
  logic            finish;
  logic [N*CW-1:0] a_reg;
  logic [CW-1:0]   a_head;
  logic [Q-1:0]    a_head_ext;
  logic [CNTW-1:0] cnt;
  logic            last;
  logic [N*Q-1:0]  b_load;
  logic [N*Q-1:0]  b_q;
  logic [Q-1:0]    acc      [N];
  logic [Q-1:0]    acc_next [N];
  logic [N*Q-1:0]  acc_next_flat;

  assign a_head = a_reg[CW-1:0];
  assign last   = (cnt == CNTW'(N-1));
  assign busy   = (state_q == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle controls; start is only honoured while idle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-extend each b coefficient to the accumulator width for CSR-B.
  always_comb begin
    b_load = '0;
    for (int i = 0; i < N; i++) begin
      b_load[coef_lsb(i, Q) +: Q] = Q'(b_in[coef_lsb(i, CW) +: CW]);
    end
  end

  csr_rotate #(
    .N          (N),
    .W          (Q),
    .NEGATE_WRAP(NEGACYCLIC)
  ) u_csr_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(b_load),
    .rot      (step),
    .q        (b_q)
  );

  // Multiply-accumulate: the Q-wide product already truncates mod 2^Q.
  always_comb begin
    a_head_ext    = Q'(a_head);
    acc_next_flat = '0;
    for (int i = 0; i < N; i++) begin
      acc_next[i] = acc[i] + a_head_ext * b_q[coef_lsb(i, Q) +: Q];
      acc_next_flat[coef_lsb(i, Q) +: Q] = acc_next[i];
    end
  end

  // CSR-A shifter, counter, accumulators and the held result / done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      c_out <= '0;
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else begin
      done <= finish;
      if (load) begin
        a_reg <= a_in;
        cnt   <= '0;
        for (int i = 0; i < N; i++) begin
          acc[i] <= '0;
        end
      end else if (step) begin
        a_reg <= a_reg >> CW;
        cnt   <= cnt + 1'b1;
        for (int i = 0; i < N; i++) begin
          acc[i] <= acc_next[i];
        end
        if (finish) begin
          c_out <= acc_next_flat;
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_mul_csr_param.sv
// Self-checking bench: four multiplier configurations checked against a
// plain-arithmetic polynomial product reference.
module tb_poly_mul_csr_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4;
  logic        start8;
  logic [3:0]  a4, b4;
  logic [31:0] a8, b8;

  logic        busy4c, busy4n, busy8c, busy8n;
  logic        done4c, done4n, done8c, done8n;
  logic [7:0]  c4c, c4n;
  logic [63:0] c8c, c8n;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  poly_mul_csr_param #(.N(4), .CW(1), .Q(2), .NEGACYCLIC(0)) dut4c (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4c), .done(done4c), .c_out(c4c));

  poly_mul_csr_param #(.N(4), .CW(1), .Q(2), .NEGACYCLIC(1)) dut4n (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4n), .done(done4n), .c_out(c4n));

  poly_mul_csr_param #(.N(8), .CW(4), .Q(8), .NEGACYCLIC(0)) dut8c (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8c), .done(done8c), .c_out(c8c));

  poly_mul_csr_param #(.N(8), .CW(4), .Q(8), .NEGACYCLIC(1)) dut8n (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8n), .done(done8n), .c_out(c8n));

  // Direct polynomial product with ring reduction, coefficients mod 2^q.
  function automatic logic [63:0] refMul(input logic [63:0] a, input logic [63:0] b,
                                         input int n, input int cw, input int q,
                                         input bit neg);
    longint      c [8];
    longint      ai, bj, p, m;
    int          k;
    logic [63:0] r;
    m = (longint'(1) << q) - 1;
    for (int i = 0; i < 8; i++) c[i] = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        ai = longint'((a >> (i * cw)) & ((64'd1 << cw) - 64'd1));
        bj = longint'((b >> (j * cw)) & ((64'd1 << cw) - 64'd1));
        p  = ai * bj;
        k  = i + j;
        if (k >= n) begin
          k = k - n;
          if (neg) p = -p;
        end
        c[k] = c[k] + p;
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = r | (64'(c[i] & m) << (i * q));
    end
    return r;
  endfunction

  // Counts every comparison and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Starts all four units together, scrambles the operands after acceptance,
  // then checks latency, single done pulse and result of each unit.
  task automatic applyStimulus(input string tag, input logic [3:0] a4v, input logic [3:0] b4v,
                               input logic [31:0] a8v, input logic [31:0] b8v);
    int   lat    [4];
    int   pulses [4];
    int   expLat [4];
    logic [3:0] d;
    expLat = '{4, 4, 8, 8};
    for (int j = 0; j < 4; j++) begin
      lat[j]    = 0;
      pulses[j] = 0;
    end
    @(negedge clk);
    a4 = a4v; b4 = b4v; a8 = a8v; b8 = b8v;
    start4 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    a4 = ~a4v; b4 = ~b4v; a8 = ~a8v; b8 = ~b8v;
    checkOutput({tag, "_busy"}, {60'd0, busy4c, busy4n, busy8c, busy8n}, 64'hF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      d = {done8n, done8c, done4n, done4c};
      for (int j = 0; j < 4; j++) begin
        if (d[j]) begin
          pulses[j]++;
          if (lat[j] == 0) lat[j] = k;
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("%s_lat%0d", tag, j), 64'(lat[j]), 64'(expLat[j]));
      checkOutput($sformatf("%s_pulses%0d", tag, j), 64'(pulses[j]), 64'd1);
    end
    checkOutput({tag, "_c4c"}, {56'd0, c4c}, refMul(64'(a4v), 64'(b4v), 4, 1, 2, 1'b0));
    checkOutput({tag, "_c4n"}, {56'd0, c4n}, refMul(64'(a4v), 64'(b4v), 4, 1, 2, 1'b1));
    checkOutput({tag, "_c8c"}, c8c, refMul(64'(a8v), 64'(b8v), 8, 4, 8, 1'b0));
    checkOutput({tag, "_c8n"}, c8n, refMul(64'(a8v), 64'(b8v), 8, 4, 8, 1'b1));
  endtask

  initial begin
    int p;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    #12;
    checkOutput("rst_busy", {60'd0, busy4c, busy4n, busy8c, busy8n}, 64'd0);
    checkOutput("rst_done", {60'd0, done4c, done4n, done8c, done8n}, 64'd0);
    checkOutput("rst_c4", {48'd0, c4c, c4n}, 64'd0);
    checkOutput("rst_c8", c8c | c8n, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Basic small case plus a = b = 3*x^7 in the wide configuration.
    applyStimulus("t1", 4'b1010, 4'b0010, 32'h3000_0000, 32'h3000_0000);
    checkOutput("t1_cyc", {56'd0, c4c}, 64'h11);
    checkOutput("t2_neg", {56'd0, c4n}, 64'h13);
    checkOutput("t4_cyc", c8c, 64'h0009_0000_0000_0000);
    checkOutput("t4_neg", c8n, 64'h00F7_0000_0000_0000);

    // All-ones operands exercise accumulator wrap-around.
    applyStimulus("t3", 4'hF, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("t3_cyc", {56'd0, c4c}, 64'h00);
    checkOutput("t3_neg", {56'd0, c4n}, 64'h22);

    for (int r = 0; r < 8; r++) begin
      applyStimulus($sformatf("rnd%0d", r), 4'($urandom), 4'($urandom), $urandom, $urandom);
    end

    // Start during a run is ignored; start in the done cycle is accepted.
    @(negedge clk);
    a4 = 4'b1010; b4 = 4'b0010; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    p = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done4c) p++;
      if (k == 1) begin
        start4 = 1'b1; a4 = 4'b0111; b4 = 4'b1101;
      end
      if (k == 2) begin
        start4 = 1'b0;
        checkOutput("t5_busy", {63'd0, busy4c}, 64'd1);
      end
      if (k == 4) begin
        checkOutput("t5_done1", {63'd0, done4c}, 64'd1);
        checkOutput("t5_first_c", {56'd0, c4c}, 64'h11);
        checkOutput("t5_first_n", {56'd0, c4n}, 64'h13);
        start4 = 1'b1;
      end
      if (k == 5) begin
        start4 = 1'b0;
        checkOutput("t5_b2b_busy", {63'd0, busy4c}, 64'd1);
        checkOutput("t5_held", {56'd0, c4c}, 64'h11);
      end
      if (k == 9) begin
        checkOutput("t5_done2", {63'd0, done4c}, 64'd1);
        checkOutput("t5_second_c", {56'd0, c4c}, refMul(64'h7, 64'hD, 4, 1, 2, 1'b0));
        checkOutput("t5_second_n", {56'd0, c4n}, refMul(64'h7, 64'hD, 4, 1, 2, 1'b1));
      end
    end
    checkOutput("t5_pulses", 64'(p), 64'd2);

    // Asynchronous reset mid-run clears everything and suppresses done.
    applyStimulus("t6_pre", 4'b1010, 4'b0010, $urandom | 32'h1, $urandom | 32'h1);
    @(negedge clk);
    a4 = 4'b0110; b4 = 4'b1011; a8 = $urandom; b8 = $urandom;
    start4 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", {60'd0, busy4c, busy4n, busy8c, busy8n}, 64'd0);
    checkOutput("t6_done", {60'd0, done4c, done4n, done8c, done8n}, 64'd0);
    checkOutput("t6_c4", {48'd0, c4c, c4n}, 64'd0);
    checkOutput("t6_c8c", c8c, 64'd0);
    checkOutput("t6_c8n", c8n, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    p = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4c || done4n || done8c || done8n) p++;
    end
    checkOutput("t6_nodone", 64'(p), 64'd0);
    applyStimulus("t6_after", 4'($urandom), 4'($urandom), $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
